// File: rtl/bcd.sv
// Four-digit BCD countdown/count-up timer with a prescaled tick and a stop button.
// Counts START_COUNT down to 0000, then up to a 9999 ceiling until the button freezes it.
module bcd #(
    parameter int COUNT_MAX   = 99,
    parameter int START_COUNT = 3000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button,
    output logic [3:0] thous,
    output logic [3:0] hund,
    output logic [3:0] tens,
    output logic [3:0] units
);

    typedef enum logic [1:0] {
        COUNTDOWN,
        COUNTUP,
        STOPPED
    } state_t;

    // Index 3 is the thousands digit, index 0 the units digit.
    typedef logic [3:0][3:0] digits_t;

    localparam int PW = (COUNT_MAX > 0) ? $clog2(COUNT_MAX + 1) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_MAX);
    localparam state_t RESET_STATE = (START_COUNT == 0) ? COUNTUP : COUNTDOWN;
    localparam digits_t START_BCD = {4'(START_COUNT / 1000 % 10), 4'(START_COUNT / 100 % 10),
                                     4'(START_COUNT / 10 % 10), 4'(START_COUNT % 10)};

    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    digits_t       digits_q;
    logic          btn_meta_q;
    logic          btn_sync_q;
    logic          btn_prev_q;
    logic          tick;
    logic          press;

    function automatic digits_t bcd_inc(input digits_t v);
        digits_t r;
        logic    carry;
        // NOTE: functions model combinational logic, so blocking '=' is correct here.
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[i] == 4'd9) begin
                    r[i] = 4'd0;
                end else begin
                    r[i]  = r[i] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic digits_t bcd_dec(input digits_t v);
        digits_t r;
        logic    borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (r[i] == 4'd0) begin
                    r[i] = 4'd9;
                end else begin
                    r[i]   = r[i] - 4'd1;
                    borrow = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // NOTE: every always_comb output is assigned on all paths, so no latch is inferred.
    always_comb begin
        presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
        tick    = (state_q != STOPPED) && (presc_q == PRESC_LAST);
        press   = btn_sync_q & ~btn_prev_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_meta_q <= 1'b0;
            btn_sync_q <= 1'b0;
            btn_prev_q <= 1'b0;
        end else begin
            btn_meta_q <= button;
            btn_sync_q <= btn_meta_q;
            btn_prev_q <= btn_sync_q;
        end
    end

    // NOTE: sequential state uses non-blocking '<=' so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RESET_STATE;
            presc_q  <= '0;
            digits_q <= START_BCD;
        end else begin
            case (state_q)
                COUNTDOWN: begin
                    presc_q <= presc_d;
                    if (tick) begin
                        digits_q <= bcd_dec(digits_q);
                        if (digits_q == 16'h0001) begin
                            state_q <= COUNTUP;
                        end
                    end
                end
                COUNTUP: begin
                    // A press wins over a coincident tick: the value is not incremented.
                    if (press) begin
                        state_q <= STOPPED;
                        presc_q <= '0;
                    end else begin
                        presc_q <= presc_d;
                        if (tick && (digits_q != 16'h9999)) begin
                            digits_q <= bcd_inc(digits_q);
                        end
                    end
                end
                STOPPED: begin
                    presc_q <= '0;
                end
                default: begin
                    state_q <= RESET_STATE;
                    presc_q <= '0;
                end
            endcase
        end
    end

    assign thous = digits_q[3];
    assign hund  = digits_q[2];
    assign tens  = digits_q[1];
    assign units = digits_q[0];

endmodule

// File: tb/tb_bcd.sv
// Self-checking bench for bcd: three instances with scaled prescalers, random button
// activity, and a tick-count reference model of the displayed value.
module tb_bcd;

    localparam int CM0 = 3;
    localparam int S0  = 3000;
    localparam int CM1 = 0;
    localparam int S1  = 5;
    localparam int CM2 = 3;
    localparam int S2  = 0;

    logic clk = 1'b0;
    logic rst0 = 1'b1, btn0 = 1'b0;
    logic rst1 = 1'b1, btn1 = 1'b0;
    logic rst2 = 1'b1, btn2 = 1'b0;
    logic [3:0] th0, hu0, te0, un0;
    logic [3:0] th1, hu1, te1, un1;
    logic [3:0] th2, hu2, te2, un2;

    int errors = 0;
    int checks = 0;
    int c0 = 0, c1 = 0, c2 = 0;

    always #5 clk = ~clk;

    bcd #(.COUNT_MAX(CM0), .START_COUNT(S0)) dut0 (
        .clk(clk), .reset(rst0), .button(btn0),
        .thous(th0), .hund(hu0), .tens(te0), .units(un0)
    );
    bcd #(.COUNT_MAX(CM1), .START_COUNT(S1)) dut1 (
        .clk(clk), .reset(rst1), .button(btn1),
        .thous(th1), .hund(hu1), .tens(te1), .units(un1)
    );
    bcd #(.COUNT_MAX(CM2), .START_COUNT(S2)) dut2 (
        .clk(clk), .reset(rst2), .button(btn2),
        .thous(th2), .hund(hu2), .tens(te2), .units(un2)
    );

    // Displayed value after c clocks since reset release, from the tick-count rule.
    function automatic int model(input int c, input int cm, input int s);
        int n;
        n = c / (cm + 1);
        if (n <= s) return s - n;
        return (n - s > 9999) ? 9999 : n - s;
    endfunction

    function automatic int dval(input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] c, input logic [3:0] d);
        if ($isunknown({a, b, c, d})) return -1;
        if (a > 4'd9 || b > 4'd9 || c > 4'd9 || d > 4'd9) return -1;
        return int'(a) * 1000 + int'(b) * 100 + int'(c) * 10 + int'(d);
    endfunction

    task automatic tick_clk();
        @(posedge clk);
        if (!rst0) c0++;
        if (!rst1) c1++;
        if (!rst2) c2++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        int act;
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        btn0 = 1'b0; btn1 = 1'b0; btn2 = 1'b0;
        repeat (3) tick_clk();
        act = dval(th0, hu0, te0, un0);
        checks++;
        if (act !== S0) begin
            errors++;
            $display("FAIL reset_dut0 got=%0d exp=%0d", act, S0);
        end
        act = dval(th1, hu1, te1, un1);
        checks++;
        if (act !== S1) begin
            errors++;
            $display("FAIL reset_dut1 got=%0d exp=%0d", act, S1);
        end
        act = dval(th2, hu2, te2, un2);
        checks++;
        if (act !== S2) begin
            errors++;
            $display("FAIL reset_dut2 got=%0d exp=%0d", act, S2);
        end
        rst0 = 1'b0;
        c0   = 0;
    endtask

    // Countdown with presses that must be ignored, continuing into the count-up.
    task automatic test_countdown();
        int p[4];
        int exp, act;
        p[0] = 500 * (CM0 + 1);
        for (int i = 1; i < 4; i++) p[i] = i * 3000 + $urandom_range(100, 2400);
        while (c0 < (S0 + 151) * (CM0 + 1)) begin
            tick_clk();
            exp = model(c0, CM0, S0);
            act = dval(th0, hu0, te0, un0);
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL countdown c=%0d got=%0d exp=%0d", c0, act, exp);
            end
            for (int i = 0; i < 4; i++) begin
                if (c0 == p[i]) btn0 = 1'b1;
                if (c0 == p[i] + 40) btn0 = 1'b0;
            end
        end
        btn0 = 1'b0;
    endtask

    task automatic test_stop();
        int e, lo, hi, frozen, act;
        e  = c0;
        lo = model(e, CM0, S0);
        hi = model(e + 3, CM0, S0);
        btn0 = 1'b1;
        repeat (3) tick_clk();
        frozen = dval(th0, hu0, te0, un0);
        checks++;
        if (frozen < lo || frozen > hi) begin
            errors++;
            $display("FAIL stop_window got=%0d exp=%0d..%0d", frozen, lo, hi);
        end
        checks++;
        if (frozen !== 151) begin
            errors++;
            $display("FAIL stop_value got=%0d exp=151", frozen);
        end
        for (int k = 0; k < 440; k++) begin
            tick_clk();
            if (k == 36) btn0 = 1'b0;
            if (k == 300) btn0 = 1'b1;
            if (k == 340) btn0 = 1'b0;
            act = dval(th0, hu0, te0, un0);
            checks++;
            if (act !== frozen) begin
                errors++;
                $display("FAIL stop_hold k=%0d got=%0d exp=%0d", k, act, frozen);
            end
        end
    endtask

    task automatic test_async_reset();
        int exp, act;
        #2 rst0 = 1'b1;
        #1;
        act = dval(th0, hu0, te0, un0);
        checks++;
        if (act !== S0) begin
            errors++;
            $display("FAIL async_reset_stopped got=%0d exp=%0d", act, S0);
        end
        tick_clk();
        tick_clk();
        rst0 = 1'b0;
        c0   = 0;
        repeat (40) begin
            tick_clk();
            exp = model(c0, CM0, S0);
            act = dval(th0, hu0, te0, un0);
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL restart c=%0d got=%0d exp=%0d", c0, act, exp);
            end
        end
        #2 rst0 = 1'b1;
        #1;
        act = dval(th0, hu0, te0, un0);
        checks++;
        if (act !== S0) begin
            errors++;
            $display("FAIL async_reset_countdown got=%0d exp=%0d", act, S0);
        end
        @(negedge clk);
    endtask

    // Tick every clock: every carry chain and the 9999 ceiling are visited.
    task automatic test_carry();
        int exp, act;
        rst1 = 1'b0;
        c1   = 0;
        while (c1 < S1 + 9999 + 20) begin
            tick_clk();
            exp = model(c1, CM1, S1);
            act = dval(th1, hu1, te1, un1);
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL carry c=%0d got=%0d exp=%0d", c1, act, exp);
            end
        end
        rst1 = 1'b1;
    endtask

    // Count-up from reset (START_COUNT=0) with presses at random tick phases.
    task automatic test_random_stop();
        int n, e, lo, hi, frozen, hold, exp, act;
        for (int it = 0; it < 16; it++) begin
            rst2 = 1'b1;
            tick_clk();
            rst2 = 1'b0;
            c2   = 0;
            n = $urandom_range(0, 300);
            if (it < 4) n = n - (n % (CM2 + 1)) + it;
            repeat (n) begin
                tick_clk();
                exp = model(c2, CM2, S2);
                act = dval(th2, hu2, te2, un2);
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL countup c=%0d got=%0d exp=%0d", c2, act, exp);
                end
            end
            e  = c2;
            lo = model(e, CM2, S2);
            hi = model(e + 3, CM2, S2);
            btn2 = 1'b1;
            repeat (3) tick_clk();
            frozen = dval(th2, hu2, te2, un2);
            checks++;
            if (frozen < lo || frozen > hi || frozen > lo + 1) begin
                errors++;
                $display("FAIL rand_stop it=%0d got=%0d exp=%0d..%0d", it, frozen, lo, hi);
            end
            hold = $urandom_range(1, 10);
            for (int k = 0; k < hold + 10; k++) begin
                tick_clk();
                if (k == hold) btn2 = 1'b0;
                act = dval(th2, hu2, te2, un2);
                checks++;
                if (act !== frozen) begin
                    errors++;
                    $display("FAIL rand_hold it=%0d k=%0d got=%0d exp=%0d", it, k, act, frozen);
                end
            end
        end
        rst2 = 1'b1;
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_stop();
        test_async_reset();
        test_carry();
        test_random_stop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd.md
BCD -- requirements
Module: bcd

Interface
REQ-001 Parameter COUNT_MAX, default 99, prescaler terminal count; one tick every COUNT_MAX+1 clocks (1 us at 100 MHz).
REQ-002 Parameter START_COUNT, default 3000, countdown preload value; range 0..9999.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 button  input  1  asynchronous stop button, active-high.
REQ-006 thous  output  4  BCD thousands digit.
REQ-007 hund  output  4  BCD hundreds digit.
REQ-008 tens  output  4  BCD tens digit.
REQ-009 units  output  4  BCD units digit.

Function
REQ-010 The block SHALL have one clock domain (clk) and one asynchronous active-high reset (reset).
REQ-011 The prescaler SHALL count 0..COUNT_MAX and wrap to 0, asserting an internal one-clock tick when its value equals COUNT_MAX.
REQ-012 The prescaler SHALL run in COUNTDOWN and COUNTUP, and SHALL hold at 0 in STOPPED.
REQ-013 FSM states SHALL be COUNTDOWN, COUNTUP and STOPPED.
REQ-014 In COUNTDOWN, each tick SHALL decrement the 4-digit BCD value by 1 with per-digit borrow (digit 0 -> 9, borrow to next digit).
REQ-015 The tick that takes the value from 0001 to 0000 SHALL move COUNTDOWN -> COUNTUP; with START_COUNT=0, reset SHALL enter COUNTUP directly.
REQ-016 In COUNTUP, each tick SHALL increment the BCD value by 1 with per-digit carry (9 -> 0, carry to next digit).
REQ-017 COUNTUP SHALL saturate at 9999; further ticks hold 9999.
REQ-018 Display value after N ticks since reset release SHALL be START_COUNT-N for N <= START_COUNT, else min(N-START_COUNT, 9999), until stopped.
REQ-019 button SHALL pass through a 2-flop synchronizer; an internal rising-edge detect on the synchronized signal SHALL form the press event.
REQ-020 A press event in COUNTUP SHALL move to STOPPED; the displayed value SHALL freeze no later than 3 clocks after button rises.
REQ-021 A press event in COUNTDOWN SHALL be ignored; the countdown continues.
REQ-022 In STOPPED, outputs SHALL hold until reset; further presses and button release SHALL have no effect.
REQ-023 A press event and a tick in the same clock in COUNTUP SHALL give STOPPED with the value not incremented.
REQ-024 Outputs SHALL be registered and driven directly from the digit registers; each digit SHALL always hold a value in 0..9.

Reset
REQ-025 While reset is high, the block SHALL hold digits = START_COUNT (3,0,0,0 by default), state COUNTDOWN, prescaler 0, and synchronizer flops 0.
REQ-026 Reset asserted at any time, including mid-countdown, mid-count-up or STOPPED, SHALL restore the REQ-025 state immediately and asynchronously.
REQ-027 After reset release, the first tick SHALL occur COUNT_MAX+1 clocks later.

Verification
REQ-028 Reset 10 ns, button low -> outputs 3000 during reset; at 100 us after release value is 2900; at 3000 us value 0000.
REQ-029 Release reset, idle 3151 us (3151 ticks), press button for 10 us -> display freezes at 0151 and stays 0151 for the next 100 us and after release.
REQ-030 Press button for 10 us during countdown at 500 us -> ignored; value 2500 at 500 us, 0000 at 3000 us, then counting up.
REQ-031 Run with COUNT_MAX=0 (tick every clock) -> count up through 0009 -> 0010, 0099 -> 0100, 0999 -> 1000 with correct carries; saturation at 9999.
REQ-032 Stop the count in COUNTUP, then assert reset -> outputs 3000 asynchronously; countdown restarts.
REQ-033 Assert the button exactly on a tick clock in COUNTUP -> frozen value equals the pre-tick value + at most 1 per REQ-020/REQ-023.
